// File: rtl/jk_count_seq_pkg.sv
// Shared types and constants for the JK flip-flop bank sequencer.
package jk_count_pkg;

  localparam int OP_W      = 2;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_STEPW = 8;

  // Command opcodes as carried on cmd_op.
  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True for the two opcodes that make the bank count.
  function automatic logic is_count(input op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/jk_count_seq_if.sv
// Command handshake between a command source and the JK bank sequencer.
interface jk_count_seq_if #(
  parameter int WIDTH = jk_count_pkg::DEF_WIDTH,
  parameter int STEPW = jk_count_pkg::DEF_STEPW
);
  import jk_count_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [STEPW-1:0] cmd_steps;

  // Command source side.
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_steps,
    input  cmd_ready
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_steps,
    output cmd_ready
  );

endinterface

// File: rtl/jk_count_seq_toggle_mask.sv
// Toggle mask for a synchronous binary up/down counter built from JK
// flip-flops: bit i toggles when all lower bits are 1 (up) or 0 (down).
// terminal flags the state from which the next count wraps.
module jk_toggle_mask #(
  parameter int WIDTH = jk_count_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             down,
  output logic [WIDTH-1:0] t,
  output logic             terminal
);

  logic [WIDTH-1:0] qd;
  logic             acc;

  // Ripple AND of the (optionally inverted) lower bits.
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
    t        = '0;
    qd       = down ? ~q : q;
    acc      = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = acc;
      acc  = acc & qd[i];
    end
    terminal = acc;
  end

endmodule

// File: rtl/jk_count_seq.sv
// Sequencer for a bank of WIDTH external JK flip-flops: accepts LOAD /
// COUNT_UP / COUNT_DOWN / HOLD commands and drives J/K from its own state
// and the bank's Q feedback.
module jk_count_seq
  import jk_count_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPW = DEF_STEPW
) (
  input  logic             CLK,
  input  logic             Clear,
  jk_count_seq_if.slave    cmd,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state, state_nxt;
  logic [STEPW-1:0] steps_left;
  op_e              op_r;
  logic [WIDTH-1:0] data_r;
  logic             wrap_r;
  logic [WIDTH-1:0] tmask;
  logic             terminal;
  logic             accept;

  // Ready is only raised in IDLE, so a transfer always starts from IDLE.
  assign accept = cmd.cmd_valid && cmd.cmd_ready;

  jk_toggle_mask #(.WIDTH(WIDTH)) u_mask (
    .q        (q_fb),
    .down     (op_r == OP_DOWN),
    .t        (tmask),
    .terminal (terminal)
  );

  // State register.
  always_ff @(posedge CLK or negedge Clear) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!Clear) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd.cmd_op == OP_LOAD)    state_nxt = ST_LOAD;
          else if (cmd.cmd_steps != '0) state_nxt = ST_RUN;
          else                          state_nxt = ST_DONE;
        end
      end
      ST_LOAD: state_nxt = ST_DONE;
      ST_RUN:  if (steps_left == STEPW'(1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, step counter and registered wrap pulse.
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      steps_left <= '0;
      op_r       <= OP_HOLD;
      data_r     <= '0;
      wrap_r     <= 1'b0;
    end else begin
      wrap_r <= (state == ST_RUN) && is_count(op_r) && terminal;
      if (accept) begin
        op_r       <= cmd.cmd_op;
        data_r     <= cmd.cmd_data;
        steps_left <= cmd.cmd_steps;
      end else if (state == ST_RUN) begin
        steps_left <= steps_left - STEPW'(1);
      end
    end
  end

  // Outputs decoded from the registered state; the bank holds unless told otherwise.
  always_comb begin
    cmd.cmd_ready = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    j             = '0;
    k             = '0;
    case (state)
      ST_IDLE: begin
        cmd.cmd_ready = 1'b1;
        busy          = 1'b0;
      end
      ST_LOAD: begin
        j = data_r;
        k = ~data_r;
      end
      ST_RUN: begin
        if (is_count(op_r)) begin
          j = tmask;
          k = tmask;
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign wrap = wrap_r;

endmodule

// File: tb/tb_jk_count_seq.sv
// Bench for jk_count_seq driving a behavioural JK flip-flop bank.
module tb_jk_count_seq;
  import jk_count_pkg::*;

  localparam int WIDTH = 4;
  localparam int STEPW = 8;

  logic             clk = 1'b0;
  logic             clear_n;
  logic             bank_clr_n;
  logic             bank_pre_n;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] j, k;
  logic             busy, done, wrap;

  int n_vec  = 0;
  int n_miss = 0;

  jk_count_seq_if #(.WIDTH(WIDTH), .STEPW(STEPW)) cmd_if ();

  jk_count_seq #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .CLK   (clk),
    .Clear (clear_n),
    .cmd   (cmd_if),
    .q_fb  (bank_q),
    .j     (j),
    .k     (k),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank with its own asynchronous Clear and Preset.
  always @(posedge clk or negedge bank_clr_n or negedge bank_pre_n) begin
    if (!bank_clr_n)      bank_q <= '0;
    else if (!bank_pre_n) bank_q <= '1;
    else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j[i], k[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= 1'b1;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Present a command from IDLE; returns at the first negedge after the accept edge.
  task automatic issue(input op_e op, input logic [WIDTH-1:0] data, input logic [STEPW-1:0] steps);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_steps = steps;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Observe one command until busy drops; bounded by a cycle budget.
  task automatic wait_done(output int cyc, output int wraps, output int dones, output int jk_nz);
    cyc = 0; wraps = 0; dones = 0; jk_nz = 0;
    while (busy && cyc < 1000) begin
      if (wrap) wraps++;
      if (done) dones++;
      if ((j | k) != '0) jk_nz++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 1000) check("busy_timeout", 32'(cyc), 32'd0);
  endtask

  typedef struct {
    op_e              op;
    logic [WIDTH-1:0] data;
    logic [STEPW-1:0] steps;
    logic [WIDTH-1:0] exp_q;
    int               exp_busy;
    int               exp_wraps;
    int               exp_jk;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int cyc, wraps, dones, jk_nz, done_seen;
    logic [WIDTH-1:0] up_seq[5];
    logic             up_wrap[5];
    logic             up_done[5];

    vecs[0]  = '{OP_LOAD, 4'b1010, 8'd0,   4'b1010, 2,   0,  1};
    vecs[1]  = '{OP_LOAD, 4'b1101, 8'd0,   4'b1101, 2,   0,  1};
    vecs[2]  = '{OP_UP,   4'b0000, 8'd3,   4'b0000, 4,   1,  3};
    vecs[3]  = '{OP_LOAD, 4'b0001, 8'd0,   4'b0001, 2,   0,  1};
    vecs[4]  = '{OP_DOWN, 4'b0000, 8'd2,   4'b1111, 3,   1,  2};
    vecs[5]  = '{OP_UP,   4'b0000, 8'd0,   4'b1111, 1,   0,  0};
    vecs[6]  = '{OP_HOLD, 4'b0000, 8'd5,   4'b1111, 6,   0,  0};
    vecs[7]  = '{OP_HOLD, 4'b0000, 8'd0,   4'b1111, 1,   0,  0};
    vecs[8]  = '{OP_LOAD, 4'b0000, 8'd0,   4'b0000, 2,   0,  1};
    vecs[9]  = '{OP_UP,   4'b0000, 8'd255, 4'b1111, 256, 15, 255};
    vecs[10] = '{OP_DOWN, 4'b0000, 8'd17,  4'b1110, 18,  1,  17};
    vecs[11] = '{OP_LOAD, 4'b0110, 8'd9,   4'b0110, 2,   0,  1};
    vecs[12] = '{OP_DOWN, 4'b0000, 8'd7,   4'b1111, 8,   1,  7};

    up_seq  = '{4'b1101, 4'b1110, 4'b1111, 4'b0000, 4'b0000};
    up_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    up_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset held with a command pending: nothing may be accepted.
    clear_n          = 1'b0;
    bank_clr_n       = 1'b0;
    bank_pre_n       = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 4'b1111;
    cmd_if.cmd_steps = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_j", 32'(j), 32'h0);
    check("rst_k", 32'(k), 32'h0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    bank_clr_n       = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    clear_n          = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_ready", 32'(cmd_if.cmd_ready), 32'h1);
    check("post_rst_q", 32'(bank_q), 32'h0);

    // LOAD 1010, cycle by cycle.
    issue(OP_LOAD, 4'b1010, 8'd0);
    check("load_j", 32'(j), 32'b1010);
    check("load_k", 32'(k), 32'b0101);
    check("load_busy", 32'(busy), 32'h1);
    check("load_done_early", 32'(done), 32'h0);
    @(negedge clk);
    check("load_q", 32'(bank_q), 32'b1010);
    check("load_done", 32'(done), 32'h1);
    check("load_done_jk", 32'(j | k), 32'h0);
    @(negedge clk);
    check("load_done_once", 32'(done), 32'h0);
    check("load_ready_after", 32'(cmd_if.cmd_ready), 32'h1);

    // COUNT_UP 3 from 1101, cycle by cycle; wrap and done share the cycle after the last edge.
    issue(OP_LOAD, 4'b1101, 8'd0);
    wait_done(cyc, wraps, dones, jk_nz);
    issue(OP_UP, 4'b0000, 8'd3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("up3_q[%0d]", i), 32'(bank_q), 32'(up_seq[i]));
      check($sformatf("up3_wrap[%0d]", i), 32'(wrap), 32'(up_wrap[i]));
      check($sformatf("up3_done[%0d]", i), 32'(done), 32'(up_done[i]));
      @(negedge clk);
    end

    // Table of whole commands, applied back to back.
    for (int v = 0; v < 13; v++) begin
      issue(vecs[v].op, vecs[v].data, vecs[v].steps);
      wait_done(cyc, wraps, dones, jk_nz);
      check($sformatf("vec%0d_q", v), 32'(bank_q), 32'(vecs[v].exp_q));
      check($sformatf("vec%0d_busy_cycles", v), 32'(cyc), 32'(vecs[v].exp_busy));
      check($sformatf("vec%0d_wraps", v), 32'(wraps), 32'(vecs[v].exp_wraps));
      check($sformatf("vec%0d_dones", v), 32'(dones), 32'd1);
      check($sformatf("vec%0d_jk_active", v), 32'(jk_nz), 32'(vecs[v].exp_jk));
    end

    // A second command held valid while busy is taken only on the first IDLE edge.
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 4'b0011;
    cmd_if.cmd_steps = 8'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_op    = OP_UP;
    cmd_if.cmd_data  = 4'b1100;
    cmd_if.cmd_steps = 8'd2;
    @(negedge clk);
    check("held_done", 32'(done), 32'h1);
    check("held_ready_in_done", 32'(cmd_if.cmd_ready), 32'h0);
    @(negedge clk);
    check("held_idle_busy", 32'(busy), 32'h0);
    check("held_idle_q", 32'(bank_q), 32'b0011);
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    wait_done(cyc, wraps, dones, jk_nz);
    check("held_busy_cycles", 32'(cyc), 32'd3);
    check("held_q", 32'(bank_q), 32'b0101);
    repeat (2) @(negedge clk);
    check("held_not_requeued_busy", 32'(busy), 32'h0);
    check("held_not_requeued_q", 32'(bank_q), 32'b0101);

    // Clear mid-RUN after 4 count edges.
    issue(OP_LOAD, 4'b0000, 8'd0);
    wait_done(cyc, wraps, dones, jk_nz);
    issue(OP_UP, 4'b0000, 8'd10);
    repeat (4) @(negedge clk);
    check("midrun_q_before", 32'(bank_q), 32'b0100);
    clear_n = 1'b0;
    #1;
    check("midrun_j", 32'(j), 32'h0);
    check("midrun_k", 32'(k), 32'h0);
    check("midrun_ready", 32'(cmd_if.cmd_ready), 32'h1);
    check("midrun_busy", 32'(busy), 32'h0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrun_q_frozen", 32'(bank_q), 32'b0100);
    clear_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrun_no_done", 32'(done_seen), 32'd0);
    check("midrun_q_after", 32'(bank_q), 32'b0100);
    issue(OP_LOAD, 4'b1001, 8'd0);
    wait_done(cyc, wraps, dones, jk_nz);
    check("after_clear_load_q", 32'(bank_q), 32'b1001);
    check("after_clear_load_done", 32'(dones), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
